// File: rtl/cam_bringup_seq.sv
// cam_bringup_seq: OV7670 power-up/config sequencer (clk_50, rst; start/stop/cfg_done/cfg_err in; pwdn/resetn/xclk_en/cfg_start/capture_en/ready/fault/state out); CAM_RETRY_EN enables config retries
module cam_bringup_seq #(
  parameter int T_RESET_CYC = 50000,
  parameter int T_SETTLE_CYC = 50000,
  parameter int T_CFG_TIMEOUT_CYC = 5000000,
  parameter int MAX_RETRY = 3
) (
  input logic clk_50,
  input logic rst,
  input logic start,
  input logic stop,
  input logic cfg_done,
  input logic cfg_err,
  output logic cam_pwdn,
  output logic cam_resetn,
  output logic xclk_en,
  output logic cfg_start,
  output logic capture_en,
  output logic ready,
  output logic fault,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, POWER = 3'd1, SETTLE = 3'd2, CONFIG = 3'd3, RUN = 3'd4, FAULT = 3'd5
  } st_t;
  localparam int T1 = T_RESET_CYC > T_SETTLE_CYC ? T_RESET_CYC : T_SETTLE_CYC;
  localparam int TMAX = T1 > T_CFG_TIMEOUT_CYC ? T1 : T_CFG_TIMEOUT_CYC;
  localparam int CW = $clog2(TMAX) + 1;
  st_t st, nxt, fail_st;
  logic [CW-1:0] cnt;
  logic done, fail;
  assign state = st;
  always_comb begin
    done = st == CONFIG && cnt != '0 && cfg_done && !cfg_err;
    fail = st == CONFIG && cnt != '0 && (cfg_err || (!cfg_done && cnt == CW'(T_CFG_TIMEOUT_CYC - 1)));
    nxt = st;
    case (st)
      IDLE, FAULT: nxt = start ? POWER : st;
      POWER: nxt = cnt == CW'(T_RESET_CYC - 1) ? SETTLE : POWER;
      SETTLE: nxt = cnt == CW'(T_SETTLE_CYC - 1) ? CONFIG : SETTLE;
      CONFIG: nxt = fail ? fail_st : done ? RUN : CONFIG;
      RUN: nxt = RUN;
      default: nxt = IDLE;
    endcase
    if (stop) nxt = IDLE;
  end
`ifdef CAM_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  logic [RW-1:0] retry;
  assign fail_st = retry < RW'(MAX_RETRY) ? POWER : FAULT;
  always_ff @(posedge clk_50) begin
    if (rst || nxt == IDLE || (nxt == RUN && st != RUN)) retry <= '0;
    else if (fail && retry < RW'(MAX_RETRY)) retry <= retry + 1'b1;
  end
`else
  assign fail_st = FAULT;
`endif
  always_ff @(posedge clk_50) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      cam_pwdn <= 1'b1;
      cam_resetn <= 1'b0;
      xclk_en <= 1'b0;
      cfg_start <= 1'b0;
      capture_en <= 1'b0;
      ready <= 1'b0;
      fault <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= nxt != st ? '0 : cnt + CW'(cnt != '1);
      cam_pwdn <= nxt == IDLE || nxt == FAULT;
      cam_resetn <= nxt == SETTLE || nxt == CONFIG || nxt == RUN;
      xclk_en <= nxt == POWER || nxt == SETTLE || nxt == CONFIG || nxt == RUN;
      cfg_start <= nxt == CONFIG && st != CONFIG;
      capture_en <= nxt == RUN;
      ready <= nxt == RUN;
      fault <= nxt == FAULT;
    end
  end
endmodule

// File: tb/tb_cam_bringup_seq.sv
// tb_cam_bringup_seq: directed test-plan scenarios plus random stimulus against a phase/age reference model
module tb_cam_bringup_seq;
  localparam int TR = 8, TS = 4, TO = 20, MR = 2;
  localparam logic [9:0] RST_VEC = 10'b000_1000000;
  logic clk_50 = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, cfg_done = 1'b0, cfg_err = 1'b0;
  logic cam_pwdn, cam_resetn, xclk_en, cfg_start, capture_en, ready, fault;
  logic [2:0] state;
  logic [9:0] obs;
  int n_chk = 0, n_fail = 0;
  int m_st = 0, m_age = 0, m_tries = 0;
  bit m_cfgs = 1'b0;
  always #10 clk_50 = ~clk_50;
  assign obs = {state, cam_pwdn, cam_resetn, xclk_en, cfg_start, capture_en, ready, fault};
  cam_bringup_seq #(.T_RESET_CYC(TR), .T_SETTLE_CYC(TS), .T_CFG_TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk_50(clk_50), .rst(rst), .start(start), .stop(stop), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cam_pwdn(cam_pwdn), .cam_resetn(cam_resetn), .xclk_en(xclk_en), .cfg_start(cfg_start),
    .capture_en(capture_en), .ready(ready), .fault(fault), .state(state)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [9:0] exp_out(int s, bit cs);
    bit live = s >= 1 && s <= 4;
    bit rel = s >= 2 && s <= 4;
    return {3'(s), !live, rel, live, cs, s == 4, s == 4, s == 5};
  endfunction
  always @(posedge clk_50) begin : model
    int ns;
    bit res_ok, res_bad;
    if (rst) begin
      m_st = 0; m_age = 0; m_tries = 0; m_cfgs = 1'b0;
    end else begin
      ns = m_st;
      res_bad = m_st == 3 && m_age > 0 && (cfg_err || (!cfg_done && m_age + 1 == TO));
      res_ok = m_st == 3 && m_age > 0 && cfg_done && !cfg_err;
      if (m_st == 0 || m_st == 5) ns = start ? 1 : m_st;
      else if (m_st == 1 && m_age + 1 == TR) ns = 2;
      else if (m_st == 2 && m_age + 1 == TS) ns = 3;
      else if (res_ok) ns = 4;
      else if (res_bad) begin
`ifdef CAM_RETRY_EN
        ns = m_tries < MR ? 1 : 5;
`else
        ns = 5;
`endif
      end
      if (stop) ns = 0;
      if (ns == 0 || (ns == 4 && m_st != 4)) m_tries = 0;
      else if (res_bad && m_tries < MR) m_tries++;
      m_cfgs = ns == 3 && m_st != 3;
      m_age = ns != m_st ? 0 : m_age + 1;
      m_st = ns;
    end
  end
  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50);
      @(negedge clk_50);
      check("model", obs, exp_out(m_st, m_cfgs));
    end
  endtask
  task automatic wait_cfg();
    for (int i = 0; i < 100 && cfg_start !== 1'b1; i++) step();
    check("cfg_start_seen", cfg_start, 1);
  endtask
  initial begin
    int k;
    step(2);
    rst = 1'b0;
    step();
    check("reset_vec", obs, RST_VEC);
    step(5);
    start = 1'b1; step(); start = 1'b0;
    check("power_entry", {state, cam_pwdn, xclk_en}, {3'd1, 1'b0, 1'b1});
    for (k = 0; k < 50 && cam_resetn !== 1'b1; k++) step();
    check("reset_len", k, TR);
    for (k = 0; k < 50 && cfg_start !== 1'b1; k++) step();
    check("settle_len", k, TS);
    step();
    check("cfg_start_single", cfg_start, 0);
    cfg_done = 1'b1; step(); cfg_done = 1'b0;
    check("run_entry", {ready, capture_en, state}, {1'b1, 1'b1, 3'd4});
    stop = 1'b1; step();
    check("stop_run", {state, capture_en, cam_pwdn}, {3'd0, 1'b0, 1'b1});
    start = 1'b1; step();
    check("start_with_stop", state, 0);
    start = 1'b0; stop = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    wait_cfg();
    cfg_err = 1'b1; cfg_done = 1'b1; step(); cfg_err = 1'b0; cfg_done = 1'b0;
    check("first_cycle_ignored", state, 3);
    for (k = 0; k < 50 && state === 3'd3; k++) step();
    check("timeout_len", k, TO - 1);
`ifdef CAM_RETRY_EN
    check("timeout_retry", state, 1);
`else
    check("timeout_fault", {fault, cam_pwdn, xclk_en, state}, {1'b1, 1'b1, 1'b0, 3'd5});
    start = 1'b1; step(); start = 1'b0;
    check("fault_restart", {state, fault}, {3'd1, 1'b0});
`endif
    for (k = 0; k < 100 && state !== 3'd2; k++) step();
    check("reach_settle", state, 2);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_in_settle", obs, RST_VEC);
    start = 1'b1; step(); start = 1'b0;
    wait_cfg();
    step();
    cfg_done = 1'b1; cfg_err = 1'b1; step(); cfg_done = 1'b0; cfg_err = 1'b0;
`ifdef CAM_RETRY_EN
    check("both_err_wins", {ready, state}, {1'b0, 3'd1});
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    k = 0;
    for (int i = 0; i < 400 && state !== 3'd5; i++) begin
      if (cfg_start === 1'b1) begin
        k++;
        step(); cfg_err = 1'b1; step(); cfg_err = 1'b0;
      end else step();
    end
    check("retry_pulses", k, MR + 1);
    check("retry_fault", state, 5);
`else
    check("both_err_wins", {ready, state}, {1'b0, 3'd5});
`endif
    for (int i = 0; i < 4000; i++) begin
      start = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 59) == 0;
      cfg_done = $urandom_range(0, 11) == 0;
      cfg_err = $urandom_range(0, 23) == 0;
      rst = $urandom_range(0, 399) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cam_bringup_seq.md
# cam_bringup_seq

Power-up and configuration sequencer for the OV7670 camera, clocked from the 50 MHz master clock. Drives camera PWDN/RESET#, gates the 25 MHz XCLK, triggers the SCCB register loader, waits for its result, and grants capture to the pixel path only after a clean bring-up. Sits between top-level control (start/stop) and the SCCB configuration and capture blocks.

## Interface
- T_RESET_CYC, 50000: cycles RESET# held low with XCLK running (1 ms).
- T_SETTLE_CYC, 50000: cycles after RESET# release before configuration starts.
- T_CFG_TIMEOUT_CYC, 5000000: maximum cycles waiting for configuration result (100 ms).
- MAX_RETRY, 3: automatic configuration retries; used only with CAM_RETRY_EN.
- clk_50  in  1  master clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin bring-up; accepted in IDLE and FAULT.
- stop  in  1  level; forces return to IDLE from any state.
- cfg_done  in  1  one-cycle pulse from SCCB loader: all registers written.
- cfg_err  in  1  one-cycle pulse from SCCB loader: NACK/bus error.
- cam_pwdn  out  1  camera power-down, 1 = powered down.
- cam_resetn  out  1  camera reset, active-low.
- xclk_en  out  1  enable for 25 MHz XCLK output gate.
- cfg_start  out  1  one-cycle pulse starting the SCCB loader.
- capture_en  out  1  pixel capture permitted.
- ready  out  1  bring-up complete (RUN state).
- fault  out  1  bring-up failed (FAULT state).
- state  out  3  current state code.

## Operation
- All outputs registered, decoded from next state; rst has priority over every input.
- States/codes: IDLE=0, POWER=1, SETTLE=2, CONFIG=3, RUN=4, FAULT=5; codes 6-7 unreachable, recover to IDLE.
- IDLE: pwdn=1, resetn=0, xclk_en=0. start & !stop -> POWER.
- POWER: pwdn=0, resetn=0, xclk_en=1; after T_RESET_CYC cycles -> SETTLE.
- SETTLE: pwdn=0, resetn=1, xclk_en=1; after T_SETTLE_CYC cycles -> CONFIG.
- CONFIG: as SETTLE; cfg_start=1 in first CONFIG cycle only. From the second CONFIG cycle: cfg_err -> failure; cfg_done -> RUN; no result within T_CFG_TIMEOUT_CYC CONFIG cycles -> failure. cfg_done/cfg_err in first CONFIG cycle ignored.
- RUN: capture_en=1, ready=1; stays until stop or rst. cfg pulses ignored.
- FAULT: fault=1, pwdn=1, resetn=0, xclk_en=0; start & !stop -> POWER (fault clears).
- stop=1 in any state -> IDLE next cycle; start ignored while stop=1.
- start outside IDLE/FAULT ignored.
- Single wait counter, width $clog2 of largest timing parameter +1, cleared on every state change; no wrap.

## Timing
- Reset values: cam_pwdn=1, cam_resetn=0, xclk_en=0, cfg_start=0, capture_en=0, ready=0, fault=0, state=0.
- start sampled at edge N in IDLE: state=1, xclk_en=1, pwdn=0 from N+1.
- cam_resetn rises at N+1+T_RESET_CYC; cfg_start high exactly at N+1+T_RESET_CYC+T_SETTLE_CYC.
- cfg_done sampled at edge M: ready=1, capture_en=1 from M+1.
- cfg_done and cfg_err same cycle: cfg_err wins.
- Timeout failure taken at edge where T_CFG_TIMEOUT_CYC CONFIG cycles completed.
- rst mid-sequence: reset values at next edge, no cfg_start emitted.

## Configuration
- CAM_RETRY_EN defined: configuration failure re-enters POWER (full reset cycle, fresh cfg_start) while retry count < MAX_RETRY; count increments per failure, clears in IDLE and on entering RUN; failure with count = MAX_RETRY -> FAULT.
- CAM_RETRY_EN undefined: any configuration failure -> FAULT directly; MAX_RETRY ignored, no retry counter.

## Test plan
- T_RESET_CYC=8, T_SETTLE_CYC=4, T_CFG_TIMEOUT_CYC=20; start at cycle 10 -> state=1 at 11, resetn high at 19, single cfg_start at 23; cfg_done at 27 -> ready=1, capture_en=1 at 28.
- rst asserted during SETTLE -> next cycle all outputs at reset values, state=0, no cfg_start.
- No cfg response -> failure after 20 CONFIG cycles; without CAM_RETRY_EN fault=1, pwdn=1, xclk_en=0; start from FAULT -> state=1, fault=0.
- cfg_done and cfg_err same cycle -> treated as error (FAULT or retry), ready stays 0.
- With CAM_RETRY_EN, MAX_RETRY=2, cfg_err every attempt -> exactly 3 cfg_start pulses, each preceded by 8-cycle resetn low, then FAULT.
- stop in RUN -> state=0, capture_en=0, pwdn=1 next cycle; start with stop=1 in IDLE -> stays IDLE.
